// File: rtl/tpu_host_seq_if.sv
// rtl/tpu_host_seq_if.sv - host/tpuv1 bus bundle for tpu_host_seq (perf_cycles present under TPU_HOST_SEQ_PERF_EN)
interface tpu_host_seq_if #(
    parameter int DATAW  = 64,
    parameter int ADDRW  = 16,
    parameter int HADDRW = 32
);
    logic              start;
    logic [HADDRW-1:0] base_a;
    logic [HADDRW-1:0] base_b;
    logic [HADDRW-1:0] base_c;
    logic [HADDRW-1:0] base_o;
    logic              busy;
    logic              done;
    logic              rd_req;
    logic [HADDRW-1:0] rd_addr;
    logic              rd_gnt;
    logic              rd_valid;
    logic [DATAW-1:0]  rd_data;
    logic              wr_req;
    logic [HADDRW-1:0] wr_addr;
    logic [DATAW-1:0]  wr_data;
    logic              wr_ack;
    logic              tpu_r_w;
    logic [ADDRW-1:0]  tpu_addr;
    logic [DATAW-1:0]  tpu_din;
    logic [DATAW-1:0]  tpu_dout;
`ifdef TPU_HOST_SEQ_PERF_EN
    logic [31:0]       perf_cycles;
`endif

    modport master (
        input  start, base_a, base_b, base_c, base_o,
        input  rd_gnt, rd_valid, rd_data, wr_ack, tpu_dout,
`ifdef TPU_HOST_SEQ_PERF_EN
        output perf_cycles,
`endif
        output busy, done, rd_req, rd_addr, wr_req, wr_addr, wr_data,
        output tpu_r_w, tpu_addr, tpu_din
    );

    modport slave (
        output start, base_a, base_b, base_c, base_o,
        output rd_gnt, rd_valid, rd_data, wr_ack, tpu_dout,
`ifdef TPU_HOST_SEQ_PERF_EN
        input  perf_cycles,
`endif
        input  busy, done, rd_req, rd_addr, wr_req, wr_addr, wr_data,
        input  tpu_r_w, tpu_addr, tpu_din
    );
endinterface

// File: rtl/tpu_host_seq.sv
// rtl/tpu_host_seq.sv - start/done command sequencer driving the tpuv1 bus (optional cycle counter: TPU_HOST_SEQ_PERF_EN)
module tpu_host_seq #(
    parameter int DIM    = 8,
    parameter int DATAW  = 64,
    parameter int ADDRW  = 16,
    parameter int HADDRW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    tpu_host_seq_if.master  bus
);
    localparam int IDXW = $clog2(2 * DIM);
    localparam int CNTW = $clog2(3 * DIM);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_WAITD, S_PUSH, S_GO, S_WAIT, S_RDC, S_WB, S_DONE
    } state_t;

    typedef enum logic [1:0] {P_A, P_B, P_C} phase_t;

    state_t            state_q, state_n;
    phase_t            phase_q, phase_n;
    logic [IDXW-1:0]   idx_q, idx_n, last_idx;
    logic [CNTW-1:0]   wcnt_q, wcnt_n;
    logic [DATAW-1:0]  word_q, word_n;
    logic [HADDRW-1:0] ba_q, bb_q, bc_q, bo_q;
    logic [HADDRW-1:0] ba_n, bb_n, bc_n, bo_n;
    logic [HADDRW-1:0] hbase;
    logic [ADDRW-1:0]  tbase;

    logic              busy_q, done_q, rd_req_q, wr_req_q, tpu_r_w_q;
    logic              busy_n, done_n, rd_req_n, wr_req_n, tpu_r_w_n;
    logic [HADDRW-1:0] rd_addr_q, wr_addr_q, rd_addr_n, wr_addr_n;
    logic [DATAW-1:0]  wr_data_q, tpu_din_q, wr_data_n, tpu_din_n;
    logic [ADDRW-1:0]  tpu_addr_q, tpu_addr_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            phase_q    <= P_A;
            idx_q      <= '0;
            wcnt_q     <= '0;
            word_q     <= '0;
            ba_q       <= '0;
            bb_q       <= '0;
            bc_q       <= '0;
            bo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_req_q   <= 1'b0;
            rd_addr_q  <= '0;
            wr_req_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            tpu_r_w_q  <= 1'b0;
            tpu_addr_q <= '0;
            tpu_din_q  <= '0;
        end else begin
            state_q    <= state_n;
            phase_q    <= phase_n;
            idx_q      <= idx_n;
            wcnt_q     <= wcnt_n;
            word_q     <= word_n;
            ba_q       <= ba_n;
            bb_q       <= bb_n;
            bc_q       <= bc_n;
            bo_q       <= bo_n;
            busy_q     <= busy_n;
            done_q     <= done_n;
            rd_req_q   <= rd_req_n;
            rd_addr_q  <= rd_addr_n;
            wr_req_q   <= wr_req_n;
            wr_addr_q  <= wr_addr_n;
            wr_data_q  <= wr_data_n;
            tpu_r_w_q  <= tpu_r_w_n;
            tpu_addr_q <= tpu_addr_n;
            tpu_din_q  <= tpu_din_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        phase_n  = phase_q;
        idx_n    = idx_q;
        wcnt_n   = wcnt_q;
        word_n   = word_q;
        ba_n     = ba_q;
        bb_n     = bb_q;
        bc_n     = bc_q;
        bo_n     = bo_q;
        last_idx = (phase_q == P_C) ? IDXW'(2 * DIM - 1) : IDXW'(DIM - 1);

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    ba_n    = bus.base_a;
                    bb_n    = bus.base_b;
                    bc_n    = bus.base_c;
                    bo_n    = bus.base_o;
                    phase_n = P_A;
                    idx_n   = '0;
                    state_n = S_FETCH;
                end
            end
            S_FETCH: begin
                // rd_valid alongside rd_gnt is a zero-wait host; valid before gnt is stale and dropped
                if (bus.rd_gnt) begin
                    if (bus.rd_valid) begin
                        word_n  = bus.rd_data;
                        state_n = S_PUSH;
                    end else begin
                        state_n = S_WAITD;
                    end
                end
            end
            S_WAITD: begin
                if (bus.rd_valid) begin
                    word_n  = bus.rd_data;
                    state_n = S_PUSH;
                end
            end
            S_PUSH: begin
                if (idx_q == last_idx) begin
                    idx_n = '0;
                    case (phase_q)
                        P_A:     begin phase_n = P_B; state_n = S_FETCH; end
                        P_B:     begin phase_n = P_C; state_n = S_FETCH; end
                        default: state_n = S_GO;
                    endcase
                end else begin
                    idx_n   = idx_q + IDXW'(1);
                    state_n = S_FETCH;
                end
            end
            S_GO: begin
                wcnt_n  = '0;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (wcnt_q == CNTW'(3 * DIM - 1)) begin
                    state_n = S_RDC;
                end else begin
                    wcnt_n = wcnt_q + CNTW'(1);
                end
            end
            S_RDC: begin
                word_n  = bus.tpu_dout;
                state_n = S_WB;
            end
            S_WB: begin
                if (bus.wr_ack) begin
                    if (idx_q == IDXW'(2 * DIM - 1)) begin
                        state_n = S_DONE;
                    end else begin
                        idx_n   = idx_q + IDXW'(1);
                        state_n = S_RDC;
                    end
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        case (phase_n)
            P_A:     begin hbase = ba_n; tbase = ADDRW'(12'h100); end
            P_B:     begin hbase = bb_n; tbase = ADDRW'(12'h200); end
            default: begin hbase = bc_n; tbase = ADDRW'(12'h300); end
        endcase

        // Outputs are decoded from the next state so that every output is a flop
        busy_n     = !(state_n == S_IDLE || state_n == S_DONE);
        done_n     = (state_n == S_DONE);
        rd_req_n   = (state_n == S_FETCH);
        rd_addr_n  = rd_req_n ? hbase + HADDRW'(idx_n) : '0;
        wr_req_n   = (state_n == S_WB);
        wr_addr_n  = wr_req_n ? bo_n + HADDRW'(idx_n) : '0;
        wr_data_n  = wr_req_n ? word_n : '0;
        tpu_r_w_n  = (state_n == S_PUSH) || (state_n == S_GO);
        tpu_din_n  = (state_n == S_PUSH) ? word_n : '0;
        case (state_n)
            S_PUSH:  tpu_addr_n = tbase + (ADDRW'(idx_n) << 3);
            S_GO:    tpu_addr_n = ADDRW'(12'h400);
            S_RDC:   tpu_addr_n = ADDRW'(12'h300) + (ADDRW'(idx_n) << 3);
            default: tpu_addr_n = '0;
        endcase
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rd_req   = rd_req_q;
    assign bus.rd_addr  = rd_addr_q;
    assign bus.wr_req   = wr_req_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.tpu_r_w  = tpu_r_w_q;
    assign bus.tpu_addr = tpu_addr_q;
    assign bus.tpu_din  = tpu_din_q;

`ifdef TPU_HOST_SEQ_PERF_EN
    logic [31:0] perf_q;

    // Counts every non-idle cycle, so the done cycle is included
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (state_q == S_IDLE) begin
            if (bus.start) begin
                perf_q <= '0;
            end
        end else if (perf_q != 32'hFFFF_FFFF) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign bus.perf_cycles = perf_q;
`endif
endmodule
